// File: rtl/alu_mc_core.sv
// Multi-cycle 8-bit ALU: single-cycle logic/arith ops, iterative shift-add multiply,
// optional restoring divide enabled by the ALU_MC_CORE_DIV_EN macro.
module alu_mc_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [3:0]  s,
    output logic [15:0] out,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nxt;
    logic [7:0]  op_a;
    logic [7:0]  sreg;
    logic [15:0] acc;
    logic [2:0]  cnt;
    logic        is_multi;
    logic        err_single;
    logic [15:0] mul_acc;

    function automatic logic [15:0] alu_single(input logic [7:0] x, input logic [7:0] y,
                                               input logic [3:0] op);
        logic signed [8:0] diff;
        logic [15:0]       r;
        diff = $signed({1'b0, x}) - $signed({1'b0, y});
        r    = 16'h0000;
        case (op)
            4'd0:    r = {7'b0, {1'b0, x} + {1'b0, y}};
            4'd1:    r = {{7{diff[8]}}, diff};
            4'd2:    r = {8'h00, x & y};
            4'd3:    r = {8'h00, x | y};
            4'd4:    r = {8'h00, x ^ y};
            4'd5:    r = {8'h00, ~x};
            4'd6:    r = {7'b0, x, 1'b0};
            4'd7:    r = {8'h00, 1'b0, x[7:1]};
            4'd10:   r = {14'b0, (x > y), (x == y)};
            4'd11:   r = {7'b0, {1'b0, x} + 9'd1};
            4'd12:   r = {7'b0, {1'b0, x} - 9'd1};
            4'd13:   r = {8'h00, ~(x & y)};
            4'd14:   r = {8'h00, ~(x | y)};
            4'd15:   r = {8'h00, ~(x ^ y)};
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

`ifdef ALU_MC_CORE_DIV_EN
    logic [7:0] op_b;
    logic [3:0] op_s;
    logic [8:0] rem_sh;
    logic [8:0] div_rem;
    logic       div_ge;
    logic [7:0] div_q;

    assign is_multi   = (s == 4'd8) || (s == 4'd9);
    assign err_single = 1'b0;

    // Restoring step: remainder lives in acc[8:0], dividend shifts out of sreg as quotient shifts in.
    assign rem_sh  = {acc[7:0], sreg[7]};
    assign div_ge  = (rem_sh >= {1'b0, op_b});
    assign div_rem = div_ge ? (rem_sh - {1'b0, op_b}) : rem_sh;
    assign div_q   = {sreg[6:0], div_ge};
`else
    assign is_multi   = (s == 4'd8);
    assign err_single = (s == 4'd9);
`endif

    assign mul_acc = acc + (sreg[0] ? ({8'h00, op_a} << cnt) : 16'h0000);

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = is_multi ? CALC : DONE;
            CALC:    if (cnt == 3'd7) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out  <= 16'h0000;
            err  <= 1'b0;
            op_a <= 8'h00;
            sreg <= 8'h00;
            acc  <= 16'h0000;
            cnt  <= 3'd0;
`ifdef ALU_MC_CORE_DIV_EN
            op_b <= 8'h00;
            op_s <= 4'h0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_a <= a;
                    cnt  <= 3'd0;
                    acc  <= 16'h0000;
                    sreg <= (s == 4'd8) ? b : a;
`ifdef ALU_MC_CORE_DIV_EN
                    op_b <= b;
                    op_s <= s;
`endif
                    if (!is_multi) begin
                        out <= alu_single(a, b, s);
                        err <= err_single;
                    end
                end
                CALC: begin
                    cnt <= cnt + 3'd1;
`ifdef ALU_MC_CORE_DIV_EN
                    if (op_s == 4'd9) begin
                        acc  <= {7'b0, div_rem};
                        sreg <= div_q;
                        if (cnt == 3'd7) begin
                            out <= (op_b == 8'h00) ? 16'hFFFF : {div_rem[7:0], div_q};
                            err <= (op_b == 8'h00);
                        end
                    end else
`endif
                    begin
                        acc  <= mul_acc;
                        sreg <= {1'b0, sreg[7:1]};
                        if (cnt == 3'd7) begin
                            out <= mul_acc;
                            err <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc_core.sv
// Scoreboard bench for alu_mc_core: stimulus pushes expected {out, err, done cycle},
// a negedge monitor pops and compares whenever done is high.
module tb_alu_mc_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  a, b;
    logic [3:0]  s;
    logic [15:0] out;
    logic        busy, done, err;

    typedef struct {
        logic [15:0] o;
        logic        e;
        int          c;
    } exp_t;

    exp_t        sb[$];
    exp_t        ex;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [15:0] last_out = 16'h0000;

    alu_mc_core dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .s    (s),
        .out  (out),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, want, $time);
    endtask

    // Monitor: pop on each done, otherwise out must hold its last value.
    always @(negedge clk) begin
        if (rst) begin
            last_out = 16'h0000;
        end else if (done) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_done: done with nothing pending, out=%0h", out);
            end else begin
                ex = sb.pop_front();
                chk("out", {16'h0, out}, {16'h0, ex.o});
                chk("err", {31'h0, err}, {31'h0, ex.e});
                chk("done_cycle", cyc, ex.c);
            end
            last_out = out;
        end else begin
            chk("out_hold", {16'h0, out}, {16'h0, last_out});
        end
    end

    // Lat counts cycles from the start edge to the cycle in which done is high.
    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [3:0] is,
                         input logic [15:0] eo, input logic ee, input int lat);
        exp_t t;
        @(negedge clk);
        a = ia; b = ib; s = is; start = 1'b1;
        @(posedge clk);
        #1;
        t.o = eo; t.e = ee; t.c = cyc + lat - 1;
        sb.push_back(t);
        start = 1'b0;
        a = ~ia; b = ~ib; s = ~is;
    endtask

    // Counts busy cycles until idle; optionally pulses an extra start at negedge poke_at.
    task automatic wait_idle(input string nm, input int exp_busy, input int poke_at);
        int nb = 0;
        int i  = 0;
        while (busy && i < 20) begin
            @(negedge clk);
            if (busy) nb++;
            if (i == poke_at) begin
                start = 1'b1; a = 8'h01; b = 8'h01; s = 4'd0;
            end else begin
                start = 1'b0;
            end
            i++;
        end
        start = 1'b0;
        if (busy) begin
            n_chk++;
            $display("FAIL %s_timeout: busy still high after 20 cycles", nm);
        end
        chk({nm, "_busy_cycles"}, nb, exp_busy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; s = 4'h0;
        @(negedge clk);
        chk("rst_out",  {16'h0, out}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_err",  {31'h0, err}, 32'h0);
        #2 rst = 1'b0;

        issue(8'hFF, 8'h01, 4'd0,  16'h0100, 1'b0, 1); wait_idle("add",  1, 0);
        issue(8'h03, 8'h05, 4'd1,  16'hFFFE, 1'b0, 1); wait_idle("sub",  1, -1);
        issue(8'hF0, 8'h3C, 4'd2,  16'h0030, 1'b0, 1); wait_idle("and",  1, -1);
        issue(8'hA5, 8'h0F, 4'd3,  16'h00AF, 1'b0, 1); wait_idle("or",   1, -1);
        issue(8'hA5, 8'hFF, 4'd4,  16'h005A, 1'b0, 1); wait_idle("xor",  1, -1);
        issue(8'h3C, 8'h00, 4'd5,  16'h00C3, 1'b0, 1); wait_idle("not",  1, -1);
        issue(8'h81, 8'h00, 4'd6,  16'h0102, 1'b0, 1); wait_idle("shl",  1, -1);
        issue(8'h81, 8'h00, 4'd7,  16'h0040, 1'b0, 1); wait_idle("shr",  1, -1);
        issue(8'h05, 8'h05, 4'd10, 16'h0001, 1'b0, 1); wait_idle("eq",   1, -1);
        issue(8'h09, 8'h05, 4'd10, 16'h0002, 1'b0, 1); wait_idle("gt",   1, -1);
        issue(8'h03, 8'h09, 4'd10, 16'h0000, 1'b0, 1); wait_idle("lt",   1, -1);
        issue(8'hFF, 8'h00, 4'd11, 16'h0100, 1'b0, 1); wait_idle("inc",  1, -1);
        issue(8'h00, 8'h00, 4'd12, 16'h01FF, 1'b0, 1); wait_idle("dec0", 1, -1);
        issue(8'h10, 8'h00, 4'd12, 16'h000F, 1'b0, 1); wait_idle("dec",  1, -1);
        issue(8'hF0, 8'h3C, 4'd13, 16'h00CF, 1'b0, 1); wait_idle("nand", 1, -1);
        issue(8'hF0, 8'h3C, 4'd14, 16'h0003, 1'b0, 1); wait_idle("nor",  1, -1);
        issue(8'hF0, 8'h3C, 4'd15, 16'h0033, 1'b0, 1); wait_idle("xnor", 1, 0);

        issue(8'hFF, 8'hFF, 4'd8, 16'hFE01, 1'b0, 9);
        chk("mul_busy_now", {31'h0, busy}, 32'h1);
        wait_idle("mul_ff", 9, 3);
        issue(8'h0D, 8'h0B, 4'd8, 16'h008F, 1'b0, 9); wait_idle("mul_d_b", 9, -1);
        issue(8'h00, 8'h55, 4'd8, 16'h0000, 1'b0, 9); wait_idle("mul_0",   9, -1);

`ifdef ALU_MC_CORE_DIV_EN
        issue(8'd100, 8'd7,  4'd9, 16'h020E, 1'b0, 9); wait_idle("div",    9, -1);
        issue(8'hFF,  8'h10, 4'd9, 16'h0F0F, 1'b0, 9); wait_idle("div_ff", 9, -1);
        issue(8'd100, 8'd0,  4'd9, 16'hFFFF, 1'b1, 9); wait_idle("div0",   9, -1);
`else
        issue(8'd9, 8'd3, 4'd9, 16'h0000, 1'b1, 1); wait_idle("op9_illegal", 1, -1);
`endif
        issue(8'h01, 8'h01, 4'd0, 16'h0002, 1'b0, 1); wait_idle("err_clear", 1, -1);

        // Reset in the middle of a multiply: abort, no done, then immediate restart.
        issue(8'hFF, 8'hFF, 4'd8, 16'hFE01, 1'b0, 9);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        sb.delete();
        #1;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_out",  {16'h0, out}, 32'h0);
        chk("abort_done", {31'h0, done}, 32'h0);
        chk("abort_err",  {31'h0, err}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        a = 8'hF0; b = 8'h3C; s = 4'd2; start = 1'b1;
        @(posedge clk);
        #1;
        ex.o = 16'h0030; ex.e = 1'b0; ex.c = cyc;
        sb.push_back(ex);
        start = 1'b0;
        wait_idle("post_rst", 1, -1);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_mc_core.md
ALU_MC_CORE -- requirements
Module: alu_mc_core

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named as listed below.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request strobe; sampled only in IDLE.
REQ-005 a  input  8  operand A, unsigned unless stated otherwise.
REQ-006 b  input  8  operand B, unsigned unless stated otherwise.
REQ-007 s  input  4  opcode.
REQ-008 out  output  16  registered result; holds its value until the next done.
REQ-009 busy  output  1  high whenever the state is not IDLE.
REQ-010 done  output  1  one-cycle pulse marking a new valid out.
REQ-011 err  output  1  valid with done; high for divide-by-zero or an illegal opcode.

Function
REQ-012 FSM states SHALL be IDLE, CALC and DONE.
- IDLE->DONE: start=1 with a single-cycle opcode.
- IDLE->CALC: start=1 with opcode 8 or 9.
- CALC->DONE: after exactly 8 iteration cycles.
- DONE->IDLE: unconditional.
REQ-013 a, b and s SHALL be captured on the start edge; later changes to these inputs SHALL NOT affect the operation in flight.
REQ-014 Latency from the start edge to done SHALL be:
- single-cycle opcodes: 1 cycle;
- opcodes 8 and 9: 9 cycles.
REQ-015 start SHALL be ignored while busy=1, including in the DONE cycle; no request is queued.
REQ-016 done and the out/err update SHALL occur on the same edge; done SHALL be high only in the DONE state.
REQ-017 Opcode map (results zero-extended to 16 bits unless noted):
- 0: a+b as a 9-bit value, carry in bit 8.
- 1: a-b, sign-extended two's complement.
- 2: a&b.
- 3: a|b.
- 4: a^b.
- 5: ~a.
- 6: a<<1, 9 bits.
- 7: a>>1.
- 8: a*b, 16 bits, iterative shift-add.
- 9: {remainder, quotient}, iterative restoring divide.
- 10: a==b in bit 0, a>b in bit 1.
- 11: a+1, 9 bits.
- 12: a-1, 9 bits, borrow in bit 8.
- 13: ~(a&b).
- 14: ~(a|b).
- 15: ~(a^b).
REQ-018 Opcode 9 with b=0 SHALL still take 9 cycles, set out=16'hFFFF and set err=1.
REQ-019 err SHALL be 0 for every other opcode and operand combination.
REQ-020 The multiplier SHALL use an 8-bit multiplier shift register, a 16-bit accumulator and a 3-bit iteration counter that wraps 7->0 at the CALC exit.
REQ-021 out SHALL change only on a done edge or on reset.

Reset
REQ-022 rst=1 SHALL immediately force:
- state = IDLE;
- out = 16'h0000;
- busy = 0, done = 0, err = 0;
- iteration counter and all internal registers = 0.
REQ-023 Reset asserted mid-CALC SHALL abort the operation with no done pulse.
REQ-024 After rst deasserts, a start on the first following rising edge SHALL be accepted.

Configuration
REQ-025 The macro ALU_MC_CORE_DIV_EN SHALL control the divider.
REQ-026 With ALU_MC_CORE_DIV_EN defined:
- opcode 9 SHALL behave as in REQ-017 and REQ-018.
REQ-027 Without ALU_MC_CORE_DIV_EN:
- no divider logic SHALL be present;
- opcode 9 SHALL be a single-cycle illegal opcode: done after 1 cycle, out=16'h0000, err=1.

Verification
REQ-028 a=8'hFF, b=8'h01, s=0, start -> done 1 cycle later, out=16'h0100, err=0.
REQ-029 a=8'h03, b=8'h05, s=1 -> out=16'hFFFE.
REQ-030 a=8'hFF, b=8'hFF, s=8, start -> busy high 9 cycles, done at cycle 9, out=16'hFE01.
- a second start at cycle 4 is ignored.
REQ-031 With DIV_EN: a=8'd100, b=8'd7, s=9 -> out=16'h020E (remainder 2, quotient 14), err=0.
- Same with b=0 -> out=16'hFFFF, err=1.
REQ-032 Start s=8, then assert rst at cycle 5 -> busy=0 and out=0 immediately, no done pulse.
- Start s=2, a=8'hF0, b=8'h3C on the next edge -> out=16'h0030 after 1 cycle.
REQ-033 Without DIV_EN: s=9, a=8'd9, b=8'd3 -> done after 1 cycle, out=16'h0000, err=1.
